memy_access_ctrl: RTL and testbench
===================================

// Module: memy_access_ctrl
// PURPOSE
//  Initiator for the MemY memory port. Accepts burst read/write commands over
//  valid/ready handshakes and sequences the address, A/B data and
//  WrtEnbY/notWrtEnbY strobes. Returns 64-bit read beats from memY_dataout.
//  Sits between the AES datapath/host bridge and the MemY memory hierarchy.
// PARAMETERS
//  ADDR_W  8   word address width; bursts wrap modulo 2**ADDR_W
//  DATA_W  64  beat width; A = upper DATA_W/2 bits, B = lower DATA_W/2 bits
//  RD_LAT  1   cycles from read-strobe cycle at memory port to valid memY_dataout
// PORTS
//  clock         in   1       sole clock, all logic on posedge
//  reset         in   1       synchronous, active-high
//  cmd_valid     in   1       command offered
//  cmd_ready     out  1       high only in IDLE
//  cmd_write     in   1       1=write burst, 0=read burst
//  cmd_addr      in   ADDR_W  burst start address
//  cmd_len       in   ADDR_W  beats minus one (0 => 1 beat, 255 => 256 beats)
//  wr_valid      in   1       write beat offered
//  wr_ready      out  1       write beat accepted when wr_valid&wr_ready
//  wr_data       in   DATA_W  write beat
//  rd_valid      out  1       read beat valid
//  rd_ready      in   1       read backpressure (used only with MEMY_RDBUF_EN)
//  rd_data       out  DATA_W  read beat
//  rd_last       out  1       final beat of read burst
//  done          out  1       one-cycle pulse when a burst fully completes
//  common_address out ADDR_W  registered memory address
//  A / B         out  DATA_W/2 registered write data halves
//  WrtEnbY       out  1       registered write strobe, one cycle per beat
//  notWrtEnbY    out  1       registered read strobe, one cycle per beat
//  memY_dataout  in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1. Reset mid-burst aborts
//   immediately; in-flight reads are discarded, no rd_valid/done after reset.
//  IDLE: cmd_ready=1; on cmd_valid capture addr/len/dir -> WR or RD next cycle.
//  WR: wr_ready=1. Per accepted beat, next cycle: common_address=addr,
//   {A,B}=wr_data, WrtEnbY=1 (else 0). addr+=1 mod 2**ADDR_W. After beat len+1
//   -> IDLE; done pulses with the last WrtEnbY cycle. No wr_valid => no strobe.
//  RD: one read issued per cycle (notWrtEnbY=1, common_address=addr), addr+=1
//   with wrap. rd_valid/rd_data appear RD_LAT cycles after each strobe cycle,
//   in issue order; rd_last on beat len+1. After last issue -> DRAIN.
//  DRAIN: no strobes; when in-flight count=0 -> IDLE, done with rd_last beat.
//  WrtEnbY and notWrtEnbY are never both 1. Strobes and cmd_ready are never
//   high in the same cycle. Back-to-back bursts: cmd_ready returns the cycle
//   after done.
//  A, B and common_address hold their last value when no strobe is active.
//  An in-flight counter (0..RD_LAT+1) tracks issued reads that are not yet
//   returned.
// CONFIGURATION
//  MEMY_RDBUF_EN defined: (RD_LAT+1)-entry read FIFO in front of rd_*. A beat
//   leaves on rd_valid&rd_ready. A read is issued only if fifo_count+in_flight
//   < RD_LAT+1, so no read beat is ever dropped. DRAIN waits for the FIFO to
//   empty. done coincides with the rd_last handshake.
//  Undefined: rd_ready is ignored and there is no FIFO. rd_* is driven straight
//   from the latency pipeline and reads issue every cycle. The consumer must
//   accept every beat.
// TESTING
//  1 write addr=0x10 len=3, data 0x1111..,0x2222..,0x3333..,0x4444.. ->
//    WrtEnbY 4 cycles, addresses 0x10..0x13, A/B split correct, done on 4th.
//  2 read addr=0x10 len=3 after test 1 -> rd_data 0x1111..0x4444.. in order,
//    rd_last on beat 4, done once.
//  3 write addr=0xFE len=3 -> addresses FE,FF,00,01; read back matches.
//  4 write burst with wr_valid gapped (1 on, 2 off) -> WrtEnbY only on
//    accepted beats, addresses contiguous.
//  5 reset asserted during read beat 2 of len=7 -> next cycle all outputs 0,
//    cmd_ready=1, no further rd_valid/done.
//  6 MEMY_RDBUF_EN, rd_ready=0 for 5 cycles mid len=7 read -> issue stalls,
//    at most RD_LAT+1 beats buffered, all 8 beats delivered exactly once.

Source files
------------

// File: rtl/memy_access_ctrl.sv
// -----------------------------------------------------------------------------
// memy_access_ctrl
// Initiator for the MemY memory port. Takes burst read/write commands over a
// valid/ready handshake and sequences common_address, the A/B write halves and
// the WrtEnbY / notWrtEnbY strobes. Read beats come back from memY_dataout
// RD_LAT cycles after each read-strobe cycle.
//
// Optional feature: define MEMY_RDBUF_EN to add an (RD_LAT+1)-entry read FIFO
// in front of rd_*. This FIFO honours rd_ready, and read issue is throttled so
// that no beat can be dropped. Without the macro, rd_ready is ignored and the
// consumer must take every beat.
//
// Ports
//   clock, reset       sole clock (posedge), synchronous active-high reset
//   cmd_*              burst command: write/read, start address, beats-1
//   wr_valid/ready/data write beat handshake (DATA_W bits)
//   rd_valid/ready/data/last read beat stream
//   done               one-cycle pulse when a burst fully completes
//   common_address,A,B registered memory address and write data halves
//   WrtEnbY/notWrtEnbY registered write/read strobes, one cycle per beat
//   memY_dataout       memory read data
// -----------------------------------------------------------------------------
module memy_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W-1:0]   cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic [ADDR_W-1:0]   common_address,
  output logic [DATA_W/2-1:0] A,
  output logic [DATA_W/2-1:0] B,
  output logic                WrtEnbY,
  output logic                notWrtEnbY,
  input  logic [DATA_W-1:0]   memY_dataout
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CNT_W  = $clog2(RD_LAT + 2);
  localparam int SUM_W  = CNT_W + 1;

  // WFIN holds off cmd_ready for the cycle in which the last write strobe and
  // done are on the port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WFIN  = 3'd2,
    S_RD    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [HALF_W-1:0] a_q, a_d, b_q, b_d;
  logic              we_q, we_d;
  logic              wdone_q, wdone_d;
  // Bit 0 is the read-strobe register itself; bit RD_LAT marks a returning beat.
  logic [RD_LAT:0]   vld_q, vld_d;
  logic [RD_LAT:0]   lst_q, lst_d;
  logic [CNT_W-1:0]  infl_q, infl_d;
  logic              credit_s, issue_s, ret_s, rd_done_s, drain_empty_s;

  assign ret_s   = vld_q[RD_LAT];
  assign issue_s = (state_q == S_RD) && credit_s;

`ifdef MEMY_RDBUF_EN
  localparam int FD = RD_LAT + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  logic [DATA_W:0]  fifo_mem_q [FD];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             pop_s;
  logic [DATA_W:0]  head_s;

  assign head_s    = fifo_mem_q[rp_q];
  assign rd_valid  = (fcnt_q != {CNT_W{1'b0}});
  assign rd_data   = rd_valid ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
  assign rd_last   = rd_valid & head_s[DATA_W];
  assign pop_s     = rd_valid & rd_ready;
  assign rd_done_s = pop_s & rd_last;
  // Occupancy plus outstanding reads must stay below the FIFO depth; a pop in
  // this cycle frees a slot early.
  assign credit_s  = (SUM_W'(fcnt_q) + SUM_W'(infl_q)) < (SUM_W'(FD) + SUM_W'(pop_s));

  // FIFO pointer and occupancy next-state
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fcnt_d = fcnt_q;
    if (ret_s) begin
      wp_d = (wp_q == PW'(FD - 1)) ? {PW{1'b0}} : wp_q + PW'(1);
    end else begin
      wp_d = wp_q;
    end
    if (pop_s) begin
      rp_d = (rp_q == PW'(FD - 1)) ? {PW{1'b0}} : rp_q + PW'(1);
    end else begin
      rp_d = rp_q;
    end
    if (ret_s && !pop_s) begin
      fcnt_d = fcnt_q + CNT_W'(1);
    end else if (!ret_s && pop_s) begin
      fcnt_d = fcnt_q - CNT_W'(1);
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  assign drain_empty_s = (infl_d == {CNT_W{1'b0}}) && (fcnt_d == {CNT_W{1'b0}});

  // FIFO storage; entries are only read while fcnt_q says they are valid
  always_ff @(posedge clock) begin
    if (ret_s) begin
      fifo_mem_q[wp_q] <= {lst_q[RD_LAT], memY_dataout};
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q   <= {PW{1'b0}};
      rp_q   <= {PW{1'b0}};
      fcnt_q <= {CNT_W{1'b0}};
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fcnt_q <= fcnt_d;
    end
  end
`else
  logic unused_rd_ready_s;

  assign unused_rd_ready_s = rd_ready;
  assign rd_valid          = ret_s;
  // Gated so rd_data reads zero whenever no beat is being presented.
  assign rd_data           = ret_s ? memY_dataout : {DATA_W{1'b0}};
  assign rd_last           = ret_s & lst_q[RD_LAT];
  assign rd_done_s         = rd_last;
  assign credit_s          = 1'b1;
  assign drain_empty_s     = (infl_d == {CNT_W{1'b0}});
`endif

  // Read latency pipeline and in-flight counter next-state
  always_comb begin
    vld_d = {vld_q[RD_LAT-1:0], issue_s};
    lst_d = {lst_q[RD_LAT-1:0], issue_s && (left_q == {ADDR_W{1'b0}})};
    if (issue_s && !ret_s) begin
      infl_d = infl_q + CNT_W'(1);
    end else if (!issue_s && ret_s) begin
      infl_d = infl_q - CNT_W'(1);
    end else begin
      infl_d = infl_q;
    end
  end

  // Burst FSM next-state and memory-port register next values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    caddr_d = caddr_q;
    a_d     = a_q;
    b_d     = b_q;
    we_d    = 1'b0;
    wdone_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          left_d  = cmd_len;
          state_d = cmd_write ? S_WR : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_valid) begin
          we_d    = 1'b1;
          caddr_d = addr_q;
          a_d     = wr_data[DATA_W-1:HALF_W];
          b_d     = wr_data[HALF_W-1:0];
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - ADDR_W'(1);
          if (left_q == {ADDR_W{1'b0}}) begin
            wdone_d = 1'b1;
            state_d = S_WFIN;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_WFIN: begin
        state_d = S_IDLE;
      end
      S_RD: begin
        if (issue_s) begin
          caddr_d = addr_q;
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - ADDR_W'(1);
          state_d = (left_q == {ADDR_W{1'b0}}) ? S_DRAIN : S_RD;
        end else begin
          state_d = S_RD;
        end
      end
      S_DRAIN: begin
        state_d = drain_empty_s ? S_IDLE : S_DRAIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and memory-port registers; reset aborts any burst at once
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      left_q  <= {ADDR_W{1'b0}};
      caddr_q <= {ADDR_W{1'b0}};
      a_q     <= {HALF_W{1'b0}};
      b_q     <= {HALF_W{1'b0}};
      we_q    <= 1'b0;
      wdone_q <= 1'b0;
      vld_q   <= {(RD_LAT + 1){1'b0}};
      lst_q   <= {(RD_LAT + 1){1'b0}};
      infl_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      caddr_q <= caddr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      we_q    <= we_d;
      wdone_q <= wdone_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      infl_q  <= infl_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign wr_ready       = (state_q == S_WR);
  assign common_address = caddr_q;
  assign A              = a_q;
  assign B              = b_q;
  assign WrtEnbY        = we_q;
  assign notWrtEnbY     = vld_q[0];
  assign done           = wdone_q | rd_done_s;

endmodule

// File: tb/tb_memy_access_ctrl.sv
// Directed testbench for memy_access_ctrl with a RD_LAT=1 MemY memory model.
module tb_memy_access_ctrl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        done;
  logic [7:0]  common_address;
  logic [31:0] A;
  logic [31:0] B;
  logic        WrtEnbY;
  logic        notWrtEnbY;
  logic [63:0] memY_dataout;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;

  memy_access_ctrl #(.ADDR_W(8), .DATA_W(64), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .common_address(common_address), .A(A), .B(B),
    .WrtEnbY(WrtEnbY), .notWrtEnbY(notWrtEnbY), .memY_dataout(memY_dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // MemY model: write on WrtEnbY, read data valid the cycle after notWrtEnbY
  logic [63:0] mem_m [256];
  logic [63:0] mem_dout;
  always @(posedge clock) begin
    if (WrtEnbY) mem_m[common_address] <= {A, B};
    if (notWrtEnbY) mem_dout <= mem_m[common_address];
  end
  assign memY_dataout = mem_dout;

  task automatic start_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    n_checks++;
    if ({wr_ready, rd_valid, rd_last, done, WrtEnbY, notWrtEnbY} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {wr_ready, rd_valid, rd_last, done, WrtEnbY, notWrtEnbY});
    end
    n_checks++;
    if ({common_address, A, B, rd_data} !== 136'b0) begin
      n_errors++;
      $display("FAIL reset_buses: got addr=%h A=%h B=%h rd=%h expected 0",
               common_address, A, B, rd_data);
    end
    reset = 1'b0;
  endtask

  // Four-beat write burst with wr_valid held high
  task automatic test_write_burst(input logic [7:0] base, input logic [63:0] d0,
                                  input logic [63:0] d1, input logic [63:0] d2,
                                  input logic [63:0] d3);
    logic [63:0] d [4];
    logic [7:0]  ea;
    d = '{d0, d1, d2, d3};
    start_cmd(1'b1, base, 8'd3);
    n_checks++;
    if (wr_ready !== 1'b1 || cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL wr_enter: wr_ready=%b cmd_ready=%b expected 1/0", wr_ready, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = d[i];
      @(negedge clock);
      wr_valid = 1'b0;
      ea = base + 8'(i);
      n_checks++;
      if (WrtEnbY !== 1'b1 || notWrtEnbY !== 1'b0 || cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL wr_strobe beat %0d: WrtEnbY=%b notWrtEnbY=%b cmd_ready=%b expected 1/0/0",
                 i, WrtEnbY, notWrtEnbY, cmd_ready);
      end
      n_checks++;
      if (common_address !== ea) begin
        n_errors++; $display("FAIL wr_addr beat %0d: got %h expected %h", i, common_address, ea);
      end
      n_checks++;
      if (A !== d[i][63:32] || B !== d[i][31:0]) begin
        n_errors++; $display("FAIL wr_ab beat %0d: got A=%h B=%h expected %h", i, A, B, d[i]);
      end
      n_checks++;
      if (done !== (i == 3) || wr_ready !== (i != 3)) begin
        n_errors++; $display("FAIL wr_done beat %0d: done=%b wr_ready=%b", i, done, wr_ready);
      end
    end
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1 || WrtEnbY !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL wr_end: cmd_ready=%b WrtEnbY=%b done=%b expected 1/0/0", cmd_ready, WrtEnbY, done);
    end
    n_checks++;
    if ({A, B} !== d3 || common_address !== base + 8'd3) begin
      n_errors++; $display("FAIL wr_hold: got addr=%h AB=%h expected %h %h", common_address, {A, B}, base + 8'd3, d3);
    end
  endtask

  // Four-beat read burst, cycle-exact against the unbuffered timing
  task automatic test_read_burst(input logic [7:0] base, input logic [63:0] d0,
                                 input logic [63:0] d1, input logic [63:0] d2,
                                 input logic [63:0] d3);
    logic [63:0] d [4];
    logic [7:0]  ea;
    logic        exp_s, exp_v;
    d = '{d0, d1, d2, d3};
    start_cmd(1'b0, base, 8'd3);
    for (int n = 1; n <= 7; n++) begin
      exp_s = (n >= 2 && n <= 5);
      exp_v = (n >= 3 && n <= 6);
      n_checks++;
      if (notWrtEnbY !== exp_s || WrtEnbY !== 1'b0) begin
        n_errors++;
        $display("FAIL rd_strobe cyc %0d: notWrtEnbY=%b WrtEnbY=%b expected %b/0", n, notWrtEnbY, WrtEnbY, exp_s);
      end
      if (exp_s) begin
        ea = base + 8'(n - 2);
        n_checks++;
        if (common_address !== ea) begin
          n_errors++; $display("FAIL rd_addr cyc %0d: got %h expected %h", n, common_address, ea);
        end
      end
      n_checks++;
      if (rd_valid !== exp_v) begin
        n_errors++; $display("FAIL rd_valid cyc %0d: got %b expected %b", n, rd_valid, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (rd_data !== d[n-3] || rd_last !== (n == 6)) begin
          n_errors++;
          $display("FAIL rd_data cyc %0d: got %h last=%b expected %h last=%b", n, rd_data, rd_last, d[n-3], (n == 6));
        end
      end
      n_checks++;
      if (done !== (n == 6) || cmd_ready !== (n == 7)) begin
        n_errors++;
        $display("FAIL rd_done cyc %0d: done=%b cmd_ready=%b expected %b/%b", n, done, cmd_ready, (n == 6), (n == 7));
      end
      @(negedge clock);
    end
  endtask

  // Write with wr_valid 1 cycle on, 2 off
  task automatic test_write_gapped();
    logic [63:0] e [3];
    e = '{64'hAAAA_0001_BBBB_0001, 64'hAAAA_0002_BBBB_0002, 64'hAAAA_0003_BBBB_0003};
    start_cmd(1'b1, 8'h40, 8'd2);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = e[i];
      @(negedge clock);
      wr_valid = 1'b0;
      n_checks++;
      if (WrtEnbY !== 1'b1 || common_address !== 8'h40 + 8'(i) || {A, B} !== e[i] || done !== (i == 2)) begin
        n_errors++;
        $display("FAIL gap_beat %0d: WrtEnbY=%b addr=%h AB=%h done=%b", i, WrtEnbY, common_address, {A, B}, done);
      end
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clock);
          n_checks++;
          if (WrtEnbY !== 1'b0 || done !== 1'b0 || common_address !== 8'h40 + 8'(i)) begin
            n_errors++;
            $display("FAIL gap_idle %0d.%0d: WrtEnbY=%b done=%b addr=%h expected 0/0/%h",
                     i, g, WrtEnbY, done, common_address, 8'h40 + 8'(i));
          end
        end
      end
    end
    @(negedge clock);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL gap_end: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  // Reset asserted while the second read beat of an 8-beat burst is presented
  task automatic test_reset_mid_read();
    int beats = 0;
    int cyc = 0;
    start_cmd(1'b0, 8'h10, 8'd7);
    while (beats < 2 && cyc < 20) begin
      if (rd_valid) beats++;
      if (beats < 2) begin
        @(negedge clock);
        cyc++;
      end
    end
    n_checks++;
    if (beats != 2 || rd_data !== D2) begin
      n_errors++; $display("FAIL rstmid_beat2: beats=%0d data=%h expected 2 %h", beats, rd_data, D2);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1 || {wr_ready, rd_valid, rd_last, done, WrtEnbY, notWrtEnbY} !== 6'b0) begin
      n_errors++;
      $display("FAIL rstmid_flags: cmd_ready=%b flags=%b expected 1 000000", cmd_ready,
               {wr_ready, rd_valid, rd_last, done, WrtEnbY, notWrtEnbY});
    end
    n_checks++;
    if ({common_address, A, B, rd_data} !== 136'b0) begin
      n_errors++; $display("FAIL rstmid_buses: addr=%h A=%h B=%h rd=%h expected 0", common_address, A, B, rd_data);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      n_checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || notWrtEnbY !== 1'b0 || cmd_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL rstmid_after %0d: rd_valid=%b done=%b notWrtEnbY=%b cmd_ready=%b", k, rd_valid, done, notWrtEnbY, cmd_ready);
      end
    end
  endtask

`ifdef MEMY_RDBUF_EN
  // Backpressure mid-burst: every beat delivered exactly once, in order
  task automatic test_rdbuf();
    logic [63:0] exp_d [8];
    int beats = 0, strobes = 0, dones = 0, cyc = 0;
    exp_d = '{D1, D2, D3, D4, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
              64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    start_cmd(1'b0, 8'h10, 8'd7);
    while (!(beats == 8 && cmd_ready) && cyc < 200) begin
      rd_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (notWrtEnbY) strobes++;
      if (done) dones++;
      n_checks++;
      if (done !== (rd_valid && rd_ready && rd_last)) begin
        n_errors++; $display("FAIL buf_done cyc %0d: done=%b", cyc, done);
      end
      if (rd_valid && rd_ready) begin
        if (beats < 8) begin
          n_checks++;
          if (rd_data !== exp_d[beats] || rd_last !== (beats == 7)) begin
            n_errors++;
            $display("FAIL buf_beat %0d: got %h last=%b expected %h", beats, rd_data, rd_last, exp_d[beats]);
          end
        end
        beats++;
      end
      @(negedge clock);
      cyc++;
    end
    rd_ready = 1'b1;
    n_checks++;
    if (cyc >= 200 || beats != 8 || strobes != 8 || dones != 1) begin
      n_errors++;
      $display("FAIL buf_totals: cyc=%0d beats=%0d strobes=%0d dones=%0d expected <200/8/8/1", cyc, beats, strobes, dones);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
    wr_valid = 1'b0; wr_data = 64'h0; rd_ready = 1'b1;
    test_reset();
    test_write_burst(8'h10, D1, D2, D3, D4);
`ifndef MEMY_RDBUF_EN
    test_read_burst(8'h10, D1, D2, D3, D4);
`endif
    test_write_burst(8'hFE, 64'hCAFE_0000_0000_00FE, 64'hCAFE_0000_0000_00FF,
                     64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001);
`ifndef MEMY_RDBUF_EN
    test_read_burst(8'hFE, 64'hCAFE_0000_0000_00FE, 64'hCAFE_0000_0000_00FF,
                    64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001);
`endif
    test_write_gapped();
    test_reset_mid_read();
`ifdef MEMY_RDBUF_EN
    test_write_burst(8'h14, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                     64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
    test_rdbuf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
